// File: rtl/dmem_dump_reader.sv
// Run-then-drain sequencer: holds the core in reset, lets it run for a fixed
// window, freezes it again, then streams a window of data memory out over valid/ready.
module dmem_dump_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RST_CYCLES = 5,
    parameter int RUN_CYCLES = 45,
    parameter int BASE_ADDR  = 0,
    parameter int DUMP_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset_x,
    input  logic              start,
    output logic              core_reset_x,
    output logic              dmem_re,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_ISSUE,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [31:0]       C_RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0]       C_RUN_LAST = 32'(RUN_CYCLES - 1);
    localparam logic [ADDR_W:0]   C_LAST_IDX = (ADDR_W + 1)'(DUMP_WORDS - 1);
    localparam logic [ADDR_W-1:0] C_BASE     = ADDR_W'(BASE_ADDR);
    localparam bit                C_NO_RUN   = (RUN_CYCLES == 0);
    localparam bit                C_NO_DUMP  = (DUMP_WORDS == 0);

    state_t              r_state;
    logic [31:0]         r_cnt;
    logic [ADDR_W:0]     r_idx;
    logic                r_core_reset_x;
    logic                r_dmem_re;
    logic [ADDR_W-1:0]   r_dmem_addr;
    logic                r_dump_valid;
    logic [ADDR_W-1:0]   r_dump_addr;
    logic [DATA_W-1:0]   r_dump_data;
    logic                r_dump_last;
    logic                r_busy;
    logic                r_done;

    // Index is one bit wider than the address so a full-memory dump cannot wrap it;
    // the memory address itself wraps modulo 2^ADDR_W.
    logic [ADDR_W:0]     w_idx_inc;
    logic [ADDR_W-1:0]   w_addr_cur;
    logic [ADDR_W-1:0]   w_addr_inc;

    assign w_idx_inc  = r_idx + (ADDR_W + 1)'(1);
    assign w_addr_cur = C_BASE + r_idx[ADDR_W-1:0];
    assign w_addr_inc = C_BASE + w_idx_inc[ADDR_W-1:0];

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_core_reset_x <= 1'b0;
            r_dmem_re      <= 1'b0;
            r_dmem_addr    <= '0;
            r_dump_valid   <= 1'b0;
            r_dump_addr    <= '0;
            r_dump_data    <= '0;
            r_dump_last    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state        <= S_HOLD;
                        r_cnt          <= '0;
                        r_idx          <= '0;
                        r_core_reset_x <= 1'b0;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == C_RST_LAST) begin
                        r_cnt <= '0;
                        if (C_NO_RUN) begin
                            r_state     <= S_ISSUE;
                            r_dmem_re   <= ~C_NO_DUMP;
                            r_dmem_addr <= w_addr_cur;
                        end else begin
                            r_state        <= S_RUN;
                            r_core_reset_x <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    if (r_cnt == C_RUN_LAST) begin
                        r_cnt          <= '0;
                        r_state        <= S_ISSUE;
                        r_core_reset_x <= 1'b0;
                        r_dmem_re      <= ~C_NO_DUMP;
                        r_dmem_addr    <= w_addr_cur;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_ISSUE: begin
                    r_dmem_re <= 1'b0;
                    if (C_NO_DUMP) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_dump_data  <= dmem_rdata;
                    r_dump_addr  <= w_addr_cur;
                    r_dump_last  <= (r_idx == C_LAST_IDX);
                    r_dump_valid <= 1'b1;
                    r_state      <= S_SEND;
                end
                S_SEND: begin
                    // Word registers are only rewritten in WAIT, so they stay put while stalled.
                    if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (r_dump_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx       <= w_idx_inc;
                            r_state     <= S_ISSUE;
                            r_dmem_re   <= 1'b1;
                            r_dmem_addr <= w_addr_inc;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_reset_x = r_core_reset_x;
    assign dmem_re      = r_dmem_re;
    assign dmem_addr    = r_dmem_addr;
    assign dump_valid   = r_dump_valid;
    assign dump_addr    = r_dump_addr;
    assign dump_data    = r_dump_data;
    assign dump_last    = r_dump_last;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench: default run/readback, backpressure, ignored starts, restart,
// asynchronous reset mid-stream and edge parameterisations.
module tb_dmem_dump_reader;

    logic clk = 1'b0;
    logic reset_x = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default instance
    logic        start0 = 1'b0, ready0 = 1'b1;
    logic        cr0, re0, valid0, last0, busy0, done0;
    logic [9:0]  addr0, daddr0;
    logic [31:0] rdata0 = 32'h0, ddata0;

    dmem_dump_reader u0 (
        .clk(clk), .reset_x(reset_x), .start(start0), .core_reset_x(cr0),
        .dmem_re(re0), .dmem_addr(addr0), .dmem_rdata(rdata0),
        .dump_valid(valid0), .dump_ready(ready0), .dump_addr(daddr0),
        .dump_data(ddata0), .dump_last(last0), .busy(busy0), .done(done0)
    );

    // Edge-parameter instances share start/ready
    logic        start_e = 1'b0, ready_e = 1'b1;
    logic        cr1, re1, valid1, last1, busy1, done1;
    logic        cr2, re2, valid2, last2, busy2, done2;
    logic        cr3, re3, valid3, last3, busy3, done3;
    logic [9:0]  addr1, daddr1, addr2, daddr2, addr3, daddr3;
    logic [31:0] rdata1 = 32'h0, ddata1, rdata2 = 32'h0, ddata2, rdata3 = 32'h0, ddata3;

    dmem_dump_reader #(.RUN_CYCLES(0), .DUMP_WORDS(2)) u1 (
        .clk(clk), .reset_x(reset_x), .start(start_e), .core_reset_x(cr1),
        .dmem_re(re1), .dmem_addr(addr1), .dmem_rdata(rdata1),
        .dump_valid(valid1), .dump_ready(ready_e), .dump_addr(daddr1),
        .dump_data(ddata1), .dump_last(last1), .busy(busy1), .done(done1)
    );
    dmem_dump_reader #(.DUMP_WORDS(0)) u2 (
        .clk(clk), .reset_x(reset_x), .start(start_e), .core_reset_x(cr2),
        .dmem_re(re2), .dmem_addr(addr2), .dmem_rdata(rdata2),
        .dump_valid(valid2), .dump_ready(ready_e), .dump_addr(daddr2),
        .dump_data(ddata2), .dump_last(last2), .busy(busy2), .done(done2)
    );
    dmem_dump_reader #(.DUMP_WORDS(1), .BASE_ADDR(1023)) u3 (
        .clk(clk), .reset_x(reset_x), .start(start_e), .core_reset_x(cr3),
        .dmem_re(re3), .dmem_addr(addr3), .dmem_rdata(rdata3),
        .dump_valid(valid3), .dump_ready(ready_e), .dump_addr(daddr3),
        .dump_data(ddata3), .dump_last(last3), .busy(busy3), .done(done3)
    );

    // Synchronous-read memory models: word i holds 0x1000+i
    always @(posedge clk) begin
        if (re0) rdata0 <= 32'h1000 + 32'(addr0);
        if (re1) rdata1 <= 32'h1000 + 32'(addr1);
        if (re2) rdata2 <= 32'h1000 + 32'(addr2);
        if (re3) rdata3 <= 32'h1000 + 32'(addr3);
    end

    // Observations of one u0 sequence
    int          pre_low, hi_cnt, post_low, rehigh, re_cnt, viol, done_cyc, last_hs_cyc, bad_gap;
    bit          timed_out;
    logic [9:0]  q_addr[$];
    logic [31:0] q_data[$];
    bit          q_last[$];
    int          q_cyc[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    // mode 0: ready high; 1: random ready + 20-cycle stall on word 3;
    // 2: ready high + start pokes in RUN and SEND; 3: stop with word 7 pending, ready low
    task automatic collect_u0(input int mode);
        int phase = 0;
        int stall = 0;
        int hold7 = 0;
        bit pv = 1'b0, phs = 1'b0, pl = 1'b0, poked_run = 1'b0, poked_send = 1'b0;
        logic [9:0]  pa = '0;
        logic [31:0] pd = '0;
        pre_low = 0; hi_cnt = 0; post_low = 0; rehigh = 0; re_cnt = 0; viol = 0;
        done_cyc = -1; last_hs_cyc = -1; bad_gap = 0; timed_out = 1'b1;
        q_addr.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (phase == 0) begin
                if (!cr0) pre_low++; else begin phase = 1; hi_cnt++; end
            end else if (phase == 1) begin
                if (cr0) hi_cnt++; else begin phase = 2; post_low++; end
            end else begin
                if (cr0) rehigh++; else post_low++;
            end
            if (re0) re_cnt++;
            if (pv && !phs && (!valid0 || ddata0 !== pd || daddr0 !== pa || last0 !== pl)) viol++;
            if (done0) begin done_cyc = cyc; timed_out = 1'b0; break; end
            if (mode == 3 && valid0 && daddr0 == 10'd7) begin
                ready0 = 1'b0;
                hold7++;
                if (hold7 == 4) begin timed_out = 1'b0; break; end
            end else if (mode == 1) begin
                if (valid0 && daddr0 == 10'd3 && stall < 20) begin
                    ready0 = 1'b0;
                    stall++;
                end else begin
                    ready0 = 1'($urandom_range(0, 1));
                end
            end else begin
                ready0 = 1'b1;
            end
            if (valid0 && ready0) begin
                if (q_cyc.size() > 0 && cyc - q_cyc[q_cyc.size()-1] != 3) bad_gap++;
                q_addr.push_back(daddr0); q_data.push_back(ddata0);
                q_last.push_back(last0);  q_cyc.push_back(cyc);
                last_hs_cyc = cyc;
            end
            pv = valid0; phs = valid0 && ready0; pa = daddr0; pd = ddata0; pl = last0;
            if (mode == 2 && phase == 1 && hi_cnt == 10 && !poked_run) begin start0 = 1'b1; poked_run = 1'b1; end
            if (mode == 2 && valid0 && daddr0 == 10'd4 && !poked_send) begin start0 = 1'b1; poked_send = 1'b1; end
            tick();
            start0 = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset_x = 1'b0;
        tick(); tick();
        n_checks++;
        if ({cr0, re0, valid0, last0, busy0, done0} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {cr0, re0, valid0, last0, busy0, done0});
        end
        n_checks++;
        if (addr0 !== 10'd0 || daddr0 !== 10'd0 || ddata0 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%0h daddr=%0h data=%0h expected 0", addr0, daddr0, ddata0);
        end
        #2 reset_x = 1'b1;
        tick();
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_default;
        pulse_start0();
        n_checks++;
        if (busy0 !== 1'b1 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy: got busy=%b done=%b expected busy=1 done=0", busy0, done0);
        end
        collect_u0(0);
        n_checks++;
        if (timed_out || pre_low != 5 || hi_cnt != 45 || rehigh != 0) begin
            n_fail++;
            $display("FAIL core_reset: got to=%0d low=%0d high=%0d rehigh=%0d expected 0/5/45/0", timed_out, pre_low, hi_cnt, rehigh);
        end
        n_checks++;
        if (q_addr.size() != 16 || re_cnt != 16) begin
            n_fail++;
            $display("FAIL word_count: got words=%0d re=%0d expected 16/16", q_addr.size(), re_cnt);
        end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== 10'(i) || q_data[i] !== 32'h1000 + 32'(i) || q_last[i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL word_%0d: got addr=%0h data=%0h last=%b expected addr=%0h data=%0h last=%b",
                         i, q_addr[i], q_data[i], q_last[i], i, 32'h1000 + 32'(i), i == 15);
            end
        end
        n_checks++;
        if (q_cyc.size() == 0 || q_cyc[0] != 52 || bad_gap != 0 || last_hs_cyc != 97 || done_cyc != 98) begin
            n_fail++;
            $display("FAIL timing: got first=%0d gaps=%0d last=%0d done=%0d expected 52/0/97/98",
                     q_cyc.size() ? q_cyc[0] : -1, bad_gap, last_hs_cyc, done_cyc);
        end
        n_checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b1 || valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL end_state: got busy=%b done=%b valid=%b expected 0/1/0", busy0, done0, valid0);
        end
        $display("test_default: %0d words, last handshake cycle %0d", q_addr.size(), last_hs_cyc);
    endtask

    task automatic test_backpressure;
        pulse_start0();
        collect_u0(1);
        ready0 = 1'b1;
        n_checks++;
        if (timed_out || q_addr.size() != 16 || viol != 0) begin
            n_fail++;
            $display("FAIL bp_stream: got to=%0d words=%0d unstable=%0d expected 0/16/0", timed_out, q_addr.size(), viol);
        end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== 10'(i) || q_data[i] !== 32'h1000 + 32'(i) || q_last[i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL bp_word_%0d: got addr=%0h data=%0h last=%b expected addr=%0h data=%0h last=%b",
                         i, q_addr[i], q_data[i], q_last[i], i, 32'h1000 + 32'(i), i == 15);
            end
        end
        n_checks++;
        if (done_cyc != last_hs_cyc + 1) begin
            n_fail++;
            $display("FAIL bp_done: got done cycle %0d expected %0d", done_cyc, last_hs_cyc + 1);
        end
        $display("test_backpressure: %0d words, done at cycle %0d", q_addr.size(), done_cyc);
    endtask

    task automatic test_start_ignored;
        pulse_start0();
        collect_u0(2);
        n_checks++;
        if (timed_out || pre_low != 5 || hi_cnt != 45 || rehigh != 0 || last_hs_cyc != 97 || done_cyc != 98) begin
            n_fail++;
            $display("FAIL poke_timing: got low=%0d high=%0d rehigh=%0d last=%0d done=%0d expected 5/45/0/97/98",
                     pre_low, hi_cnt, rehigh, last_hs_cyc, done_cyc);
        end
        n_checks++;
        if (q_addr.size() != 16 || bad_gap != 0) begin
            n_fail++;
            $display("FAIL poke_stream: got words=%0d gaps=%0d expected 16/0", q_addr.size(), bad_gap);
        end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== 10'(i) || q_data[i] !== 32'h1000 + 32'(i)) begin
                n_fail++;
                $display("FAIL poke_word_%0d: got addr=%0h data=%0h expected %0h/%0h", i, q_addr[i], q_data[i], i, 32'h1000 + 32'(i));
            end
        end
        $display("test_start_ignored: %0d words, done at cycle %0d", q_addr.size(), done_cyc);
    endtask

    task automatic test_restart;
        pulse_start0();
        n_checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || cr0 !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clear: got done=%b busy=%b core_rst=%b expected 0/1/0", done0, busy0, cr0);
        end
        collect_u0(0);
        n_checks++;
        if (timed_out || pre_low != 5 || hi_cnt != 45 || q_addr.size() != 16 || done_cyc != 98) begin
            n_fail++;
            $display("FAIL restart_run: got low=%0d high=%0d words=%0d done=%0d expected 5/45/16/98",
                     pre_low, hi_cnt, q_addr.size(), done_cyc);
        end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_checks++;
            if (q_addr[i] !== 10'(i) || q_data[i] !== 32'h1000 + 32'(i) || q_last[i] !== (i == 15)) begin
                n_fail++;
                $display("FAIL restart_word_%0d: got addr=%0h data=%0h last=%b", i, q_addr[i], q_data[i], q_last[i]);
            end
        end
        $display("test_restart: %0d words, done at cycle %0d", q_addr.size(), done_cyc);
    endtask

    task automatic test_reset_mid_send;
        pulse_start0();
        collect_u0(3);
        n_checks++;
        if (timed_out || valid0 !== 1'b1 || daddr0 !== 10'd7 || ddata0 !== 32'h1007) begin
            n_fail++;
            $display("FAIL pend_word7: got to=%0d valid=%b addr=%0h data=%0h expected 0/1/7/1007", timed_out, valid0, daddr0, ddata0);
        end
        #2 reset_x = 1'b0;
        #1;
        n_checks++;
        if ({cr0, re0, valid0, last0, busy0, done0} !== 6'b0 || daddr0 !== 10'd0 || ddata0 !== 32'd0 || addr0 !== 10'd0) begin
            n_fail++;
            $display("FAIL async_reset: got ctrl=%b daddr=%0h data=%0h addr=%0h expected all 0",
                     {cr0, re0, valid0, last0, busy0, done0}, daddr0, ddata0, addr0);
        end
        tick(); tick();
        #2 reset_x = 1'b1;
        ready0 = 1'b1;
        tick();
        pulse_start0();
        collect_u0(0);
        n_checks++;
        if (timed_out || pre_low != 5 || q_addr.size() != 16 || q_addr[0] !== 10'd0 || q_data[0] !== 32'h1000) begin
            n_fail++;
            $display("FAIL post_reset_run: got to=%0d low=%0d words=%0d first=%0h expected 0/5/16/0",
                     timed_out, pre_low, q_addr.size(), q_addr.size() ? q_addr[0] : 10'h3ff);
        end
        $display("test_reset_mid_send: restarted, %0d words", q_addr.size());
    endtask

    task automatic test_edge_params;
        int cr1_hi = 0, re2_cnt = 0, v2_cnt = 0;
        bit all_done = 1'b0;
        logic [9:0]  a1[$], a3[$];
        logic [31:0] d1[$], d3[$];
        bit          l1[$], l3[$];
        ready_e = 1'b1;
        start_e = 1'b1;
        tick();
        start_e = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cr1) cr1_hi++;
            if (re2) re2_cnt++;
            if (valid2) v2_cnt++;
            if (valid1) begin a1.push_back(daddr1); d1.push_back(ddata1); l1.push_back(last1); end
            if (valid3) begin a3.push_back(daddr3); d3.push_back(ddata3); l3.push_back(last3); end
            if (done1 && done2 && done3) begin all_done = 1'b1; break; end
            tick();
        end
        n_checks++;
        if (!all_done) begin
            n_fail++;
            $display("FAIL edge_done: got done=%b%b%b expected 111", done1, done2, done3);
        end
        n_checks++;
        if (cr1_hi != 0) begin
            n_fail++;
            $display("FAIL run0_core_reset: got %0d high cycles expected 0", cr1_hi);
        end
        n_checks++;
        if (a1.size() != 2 || a1[0] !== 10'd0 || d1[0] !== 32'h1000 || l1[0] !== 1'b0 ||
            a1[1] !== 10'd1 || d1[1] !== 32'h1001 || l1[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL run0_stream: got %0d words expected 2 (0:1000, 1:1001 last)", a1.size());
        end
        n_checks++;
        if (re2_cnt != 0 || v2_cnt != 0) begin
            n_fail++;
            $display("FAIL dump0: got re=%0d valid=%0d expected 0/0", re2_cnt, v2_cnt);
        end
        n_checks++;
        if (a3.size() != 1 || a3[0] !== 10'd1023 || d3[0] !== 32'h13FF || l3[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL top_word: got %0d words addr=%0h data=%0h expected 1 word 3ff/13ff last",
                     a3.size(), a3.size() ? a3[0] : 10'h0, a3.size() ? d3[0] : 32'h0);
        end
        $display("test_edge_params: run0 words=%0d top words=%0d dump0 re=%0d", a1.size(), a3.size(), re2_cnt);
    endtask

    initial begin
        test_reset();
        test_default();
        test_backpressure();
        test_start_ignored();
        test_restart();
        test_reset_mid_send();
        test_edge_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_dump_reader.md
# dmem_dump_reader

Harness-side sequencer that sits between the top-level bench logic and `topsim`. On a start pulse it holds the core in reset, releases it for a fixed number of run cycles, re-asserts reset to freeze the core, then reads a window of data-memory words through a synchronous read port. Each word is emitted on a valid/ready stream. It is the read-back end of the run flow: the core writes data memory, and this block drains it for checking.

## Interface
- `ADDR_W`, default 10: data-memory word-address width.
- `DATA_W`, default 32: data-memory word width.
- `RST_CYCLES`, default 5: cycles the core is held in reset before the run (minimum 1).
- `RUN_CYCLES`, default 45: cycles the core runs with reset released (0 allowed).
- `BASE_ADDR`, default 0: first word address read back.
- `DUMP_WORDS`, default 16: number of words read back (0 allowed; `BASE_ADDR+DUMP_WORDS` ≤ 2^`ADDR_W`).

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset_x` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a sequence; ignored unless in IDLE or DONE.
- `core_reset_x` out 1: active-low reset driven to `topsim.reset_x`.
- `dmem_re` out 1: data-memory read enable.
- `dmem_addr` out `ADDR_W`: data-memory read address.
- `dmem_rdata` in `DATA_W`: read data, valid exactly 1 cycle after `dmem_re`.
- `dump_valid` out 1: stream word valid.
- `dump_ready` in 1: stream sink ready.
- `dump_addr` out `ADDR_W`: address of the current stream word.
- `dump_data` out `DATA_W`: current stream word.
- `dump_last` out 1: current word is the final one.
- `busy` out 1: a sequence is in progress.
- `done` out 1: the sequence has completed; held until the next `start` or reset.

## Operation
- States: IDLE, HOLD, RUN, ISSUE, WAIT, SEND, DONE.
- IDLE: `start` moves the FSM to HOLD.
- HOLD: `core_reset_x`=0 for `RST_CYCLES` cycles, then go to RUN, or to ISSUE if `RUN_CYCLES`=0.
- RUN: `core_reset_x`=1 for exactly `RUN_CYCLES` cycles, then go to ISSUE.
- `core_reset_x` is 0 in every state except RUN. The core stays frozen during readback, and memory contents are retained.
- ISSUE: `dmem_re`=1 and `dmem_addr`=`BASE_ADDR`+index, then go to WAIT. If `DUMP_WORDS`=0, go from ISSUE straight to DONE with no read.
- WAIT: capture `dmem_rdata` into the output register, set `dump_addr`, set `dump_last`=(index==`DUMP_WORDS`-1), then go to SEND.
- SEND: `dump_valid`=1. Data, address and last are held stable until `dump_valid`&&`dump_ready`. On the handshake, increment index and go to ISSUE, or go to DONE if last.
- DONE: `done`=1. `start` clears `done` and goes to HOLD.
- `busy`=1 in every state except IDLE and DONE.
- `start` outside IDLE/DONE has no effect.
- Counters: the cycle counter is 32-bit. The index counter is `ADDR_W`+1 bits so that `DUMP_WORDS`=2^`ADDR_W` does not overflow. `dmem_addr` is computed modulo 2^`ADDR_W`.
- Reset values: FSM=IDLE; `core_reset_x`=0, `dmem_re`=0, `dmem_addr`=0, `dump_valid`=0, `dump_addr`=0, `dump_data`=0, `dump_last`=0, `busy`=0, `done`=0.
- Reset asserted mid-sequence: all outputs go to their reset values immediately (asynchronously). No partial stream word remains valid.

## Timing
- `start` is high on edge T. HOLD spans edges T+1..T+`RST_CYCLES`, and `core_reset_x` rises after edge T+`RST_CYCLES`.
- `core_reset_x`=1 for exactly `RUN_CYCLES` clock cycles.
- Read latency is 1 cycle: `dmem_re` in ISSUE, capture in WAIT, `dump_valid` in the following cycle.
- Steady-state throughput with `dump_ready` tied high: one word every 3 cycles.
- `dump_valid` never drops without a handshake, and `dump_data` never changes while `dump_valid`=1 && !`dump_ready`.
- `done` rises in the cycle after the last handshake.

## Test plan
- Defaults with `dump_ready`=1, dmem preloaded with word i = 0x1000+i: `core_reset_x` is low for 5 cycles, high for 45, then low. Stream carries addr 0..15 with data 0x1000..0x100F, and `dump_last` is set only on addr 15. `done`=1 afterwards.
- Backpressure: `dump_ready` toggles randomly, including a 20-cycle stall on word 3. Word 3 data/addr stay stable during the stall, no word is lost or duplicated, and the order is 0..15.
- Edge parameters: `RUN_CYCLES`=0 gives `core_reset_x` that never rises. `DUMP_WORDS`=0 reaches DONE with no `dmem_re` and no `dump_valid`. `DUMP_WORDS`=1 with `BASE_ADDR`=2^`ADDR_W`-1 sends exactly one word with `dump_last`=1.
- `start` pulsed during RUN and during SEND: no effect on timing or stream. `start` in DONE clears `done` and repeats the full sequence with identical output.
- `reset_x` dropped mid-SEND (word 7 pending, `dump_ready`=0): all outputs are 0 immediately. After `reset_x` is released and `start` pulses, the sequence restarts from HOLD and streams from word 0.
